stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
- Counting engine of the FPGA stopwatch, placed between the debounce/tick blocks and the 7-segment decode stage.
- Consumes the debounced push-switch levels PSW_SIG[3:0] and the 1-cycle per-second pulse SEC_SIG.
- Runs a start/stop/lap/clear state machine and a 4-digit BCD MM:SS counter.
- Drives four 4-bit digit values to time_display, plus status flags.

Parameters:
WRAP, 1, 1: 59:59 + tick wraps to 00:00; 0: saturates at 59:59.

Ports:
CLK  input  1  system clock
RSTN  input  1  asynchronous active-low reset
SEC_SIG  input  1  one-CLK-wide pulse, once per second
PSW_SIG  input  4  debounced switch levels, active-high; bit0 start/stop, bit1 lap/clear, bits3:2 unused
SEG_A_VAL  output  4  minutes tens, BCD 0-5
SEG_B_VAL  output  4  minutes ones, BCD 0-9
SEG_C_VAL  output  4  seconds tens, BCD 0-5
SEG_D_VAL  output  4  seconds ones, BCD 0-9
RUN_LED  output  1  high in RUN or LAP
LAP_LED  output  1  high in LAP
OVF  output  1  sticky rollover/saturation flag

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTN is asynchronous, active-low.
- Reset values: state IDLE; count 00:00; lap latch 00:00; all SEG_x_VAL 0; RUN_LED 0; LAP_LED 0; OVF 0; edge-detect history 0.
- Reset mid-count returns all of the above immediately, without waiting for a clock edge.
- Edge detection: a registered copy psw_d is kept. evN = PSW_SIG[N] & ~psw_d[N].
  - A held switch yields exactly one event.
  - The event acts at the same posedge at which it is detected.
  - Its result is visible on the outputs after that edge.
- States: IDLE (count 00:00, not counting), RUN (counting, display live), LAP (counting, display frozen), STOP (not counting, display live).
- Transitions on ev0 (start/stop):
  - IDLE->RUN, RUN->STOP, STOP->RUN.
  - LAP->STOP; display returns to the live count.
- Transitions on ev1 (lap/clear):
  - RUN->LAP; the live count is copied into the lap latch.
  - LAP->RUN; display returns to the live count.
  - STOP->IDLE; count is cleared to 00:00 and OVF is cleared.
  - In IDLE, ev1 is ignored.
- ev0 and ev1 in the same cycle: ev0 wins and ev1 is discarded. Bits 3:2 are ignored.
- Counting rule: the count increments on SEC_SIG only when the pre-edge state is RUN or LAP.
  - SEC_SIG coincident with ev0 from IDLE or STOP: not counted.
  - SEC_SIG coincident with ev0 from RUN: counted, then the state becomes STOP.
  - SEC_SIG coincident with RUN->LAP: the latch captures the pre-increment value, and the count increments.
- BCD arithmetic per digit:
  - Seconds ones 9->0 carries into seconds tens.
  - Seconds tens 5->0 carries into minutes ones.
  - Minutes ones 9->0 carries into minutes tens.
  - Minutes tens 5 with full carry: terminal case below.
  - No digit may ever hold a value outside its stated range.
- Terminal case at 59:59 with a counted tick:
  - WRAP=1: count becomes 00:00, OVF is set.
  - WRAP=0: count holds 59:59, OVF is set, and further ticks are no-ops.
  - OVF stays sticky until the STOP->IDLE clear or reset.
- Outputs:
  - SEG_x_VAL = lap latch in LAP, live count otherwise, selected from registered sources.
  - Latency from SEC_SIG to a new digit value is 1 CLK.
  - RUN_LED and LAP_LED are decoded from the state register.

Test Plan:
- Reset, then ev0, then 3 SEC_SIG pulses -> digits 0,0,0,3, RUN_LED=1; assert RSTN low mid-run -> all outputs 0 immediately.
- Hold PSW_SIG[0] high for 50 cycles with ticks -> only one IDLE->RUN; ev0 again after 10 ticks -> STOP at 00:10; 5 further ticks -> 00:10 unchanged.
- RUN at 00:07, ev1 -> LAP_LED=1, display frozen at 00:07 across 4 ticks; ev1 -> display 00:11 live; ev0 then ev1 -> IDLE, 00:00.
- Preload to 59:58 via ticks, WRAP=1, 2 ticks -> 59:59 then 00:00 with OVF=1; STOP+clear -> OVF=0. Rerun with WRAP=0 -> holds 59:59, OVF=1.
- PSW0 and PSW1 rising in the same cycle in RUN -> STOP, ev1 discarded; SEC_SIG coincident with ev0 from IDLE -> count stays 00:00.
- Carry check at 09:59 + 1 tick -> 10:00 in a single cycle, with no intermediate illegal digit observed.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch counting engine: start/stop/lap/clear state machine driving a
// 4-digit BCD MM:SS counter, a lap latch and a sticky overflow flag.
// Digit outputs are muxed from registered sources (lap latch in LAP, live
// count otherwise), so a tick shows up on the digits one CLK later.
module stopwatch_counter #(
  parameter bit WRAP = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       SEC_SIG,
  input  logic [3:0] PSW_SIG,
  output logic [3:0] SEG_A_VAL,
  output logic [3:0] SEG_B_VAL,
  output logic [3:0] SEG_C_VAL,
  output logic [3:0] SEG_D_VAL,
  output logic       RUN_LED,
  output logic       LAP_LED,
  output logic       OVF
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  psw_d_r;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic [15:0] lap_r;
  logic [15:0] lap_nxt_s;
  logic        ovf_r;
  logic        ovf_nxt_s;
  logic        ev0_s;
  logic        ev1_s;
  logic        tick_s;
  logic [16:0] inc_s;
  logic [15:0] disp_s;
  logic        unused_psw_s;

  // BCD increment of {min tens, min ones, sec tens, sec ones}.
  // Bit 16 of the result flags the 59:59 terminal case. Comparisons use >=
  // so a digit can never step past its legal maximum.
  function automatic logic [16:0] bcd_inc(input logic [15:0] t, input logic wrap);
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic       term;
    mt   = t[15:12];
    mo   = t[11:8];
    st   = t[7:4];
    so   = t[3:0];
    term = 1'b0;
    if (so >= 4'd9) begin
      so = 4'd0;
      if (st >= 4'd5) begin
        st = 4'd0;
        if (mo >= 4'd9) begin
          mo = 4'd0;
          if (mt >= 4'd5) begin
            term = 1'b1;
            if (wrap) begin
              mt = 4'd0;
            end else begin
              {mt, mo, st, so} = 16'h5959;
            end
          end else begin
            mt = mt + 4'd1;
          end
        end else begin
          mo = mo + 4'd1;
        end
      end else begin
        st = st + 4'd1;
      end
    end else begin
      so = so + 4'd1;
    end
    return {term, mt, mo, st, so};
  endfunction

  // Switch bits 3:2 carry no function.
  assign unused_psw_s = ^PSW_SIG[3:2];

  // Rising-edge events; start/stop has priority, so lap/clear is masked by it.
  assign ev0_s  = PSW_SIG[0] & ~psw_d_r[0];
  assign ev1_s  = PSW_SIG[1] & ~psw_d_r[1] & ~ev0_s;
  // Ticks count only when the pre-edge state is a counting state.
  assign tick_s = SEC_SIG & ((state_r == ST_RUN) | (state_r == ST_LAP));
  assign inc_s  = bcd_inc(cnt_r, WRAP);

  // Next-state decode for start/stop and lap/clear events.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ev0_s) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (ev0_s)      state_nxt_s = ST_STOP;
        else if (ev1_s) state_nxt_s = ST_LAP;
        else            state_nxt_s = ST_RUN;
      end
      ST_LAP: begin
        if (ev0_s)      state_nxt_s = ST_STOP;
        else if (ev1_s) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_LAP;
      end
      ST_STOP: begin
        if (ev0_s)      state_nxt_s = ST_RUN;
        else if (ev1_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Count, lap latch and overflow update: tick, lap capture and clear.
  always_comb begin
    cnt_nxt_s = cnt_r;
    lap_nxt_s = lap_r;
    ovf_nxt_s = ovf_r;
    if (tick_s) begin
      cnt_nxt_s = inc_s[15:0];
      ovf_nxt_s = ovf_r | inc_s[16];
    end else begin
      cnt_nxt_s = cnt_r;
      ovf_nxt_s = ovf_r;
    end
    // Lap captures the pre-increment count, even with a coincident tick.
    if ((state_r == ST_RUN) && ev1_s) begin
      lap_nxt_s = cnt_r;
    end else begin
      lap_nxt_s = lap_r;
    end
    // No tick can occur in STOP, so the clear never races an increment.
    if ((state_r == ST_STOP) && ev1_s) begin
      cnt_nxt_s = 16'h0000;
      ovf_nxt_s = 1'b0;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // State, edge history, count, lap latch and overflow registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= ST_IDLE;
      psw_d_r <= 2'b00;
      cnt_r   <= 16'h0000;
      lap_r   <= 16'h0000;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      psw_d_r <= PSW_SIG[1:0];
      cnt_r   <= cnt_nxt_s;
      lap_r   <= lap_nxt_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Display source select: frozen lap value in LAP, live count otherwise.
  always_comb begin
    disp_s = cnt_r;
    if (state_r == ST_LAP) begin
      disp_s = lap_r;
    end else begin
      disp_s = cnt_r;
    end
  end

  assign SEG_A_VAL = disp_s[15:12];
  assign SEG_B_VAL = disp_s[11:8];
  assign SEG_C_VAL = disp_s[7:4];
  assign SEG_D_VAL = disp_s[3:0];
  assign RUN_LED   = (state_r == ST_RUN) | (state_r == ST_LAP);
  assign LAP_LED   = (state_r == ST_LAP);
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: one instance with WRAP=1 and one
// with WRAP=0 share stimulus; a seconds-based reference model predicts both.
module tb_stopwatch_counter;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic       SEC_SIG;
  logic [3:0] PSW_SIG;

  logic [3:0] a1, b1, c1, d1, a0, b0, c0, d0;
  logic       run1, lap1, ovf1, run0, lap0, ovf0;
  logic [18:0] out1, out0;

  int checks = 0;
  int failures = 0;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_LAP  = 2;
  localparam int M_STOP = 3;

  // Model state: index 0 models WRAP=0, index 1 models WRAP=1.
  int         m_state;
  int         m_cnt [2];
  int         m_lap [2];
  logic       m_ovf [2];
  logic [3:0] m_psw_d;

  typedef struct {
    logic        sec;
    logic [3:0]  psw;
    logic [15:0] seg;
    logic        run;
    logic        lap;
    logic        ovf;
  } vec_t;

  vec_t vecs [13];

  stopwatch_counter #(.WRAP(1'b1)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .SEC_SIG(SEC_SIG), .PSW_SIG(PSW_SIG),
    .SEG_A_VAL(a1), .SEG_B_VAL(b1), .SEG_C_VAL(c1), .SEG_D_VAL(d1),
    .RUN_LED(run1), .LAP_LED(lap1), .OVF(ovf1)
  );

  stopwatch_counter #(.WRAP(1'b0)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .SEC_SIG(SEC_SIG), .PSW_SIG(PSW_SIG),
    .SEG_A_VAL(a0), .SEG_B_VAL(b0), .SEG_C_VAL(c0), .SEG_D_VAL(d0),
    .RUN_LED(run0), .LAP_LED(lap0), .OVF(ovf0)
  );

  assign out1 = {a1, b1, c1, d1, run1, lap1, ovf1};
  assign out0 = {a0, b0, c0, d0, run0, lap0, ovf0};

  always #5 CLK = ~CLK;

  function automatic logic [15:0] to_bcd(input int s);
    int mm;
    int ss;
    logic [3:0] d3, d2, d1_, d0_;
    mm  = s / 60;
    ss  = s % 60;
    d3  = 4'(mm / 10);
    d2  = 4'(mm % 10);
    d1_ = 4'(ss / 10);
    d0_ = 4'(ss % 10);
    return {d3, d2, d1_, d0_};
  endfunction

  task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h (seg,run,lap,ovf) expected=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_psw_d = 4'd0;
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0;
      m_lap[w] = 0;
      m_ovf[w] = 1'b0;
    end
  endtask

  // One clock edge of the stopwatch rules, in elapsed-seconds terms.
  task automatic model_step(input logic sec, input logic [3:0] psw);
    logic ev0, ev1, counting;
    ev0 = psw[0] & ~m_psw_d[0];
    ev1 = psw[1] & ~m_psw_d[1] & ~ev0;
    counting = sec && (m_state == M_RUN || m_state == M_LAP);
    for (int w = 0; w < 2; w++) begin
      if (ev1 && m_state == M_RUN) m_lap[w] = m_cnt[w];
      if (counting) begin
        if (m_cnt[w] == 3599) begin
          m_ovf[w] = 1'b1;
          m_cnt[w] = (w == 1) ? 0 : 3599;
        end else begin
          m_cnt[w] = m_cnt[w] + 1;
        end
      end
      if (ev1 && m_state == M_STOP) begin
        m_cnt[w] = 0;
        m_ovf[w] = 1'b0;
      end
    end
    if (ev0) begin
      m_state = (m_state == M_RUN || m_state == M_LAP) ? M_STOP : M_RUN;
    end else if (ev1) begin
      case (m_state)
        M_RUN:   m_state = M_LAP;
        M_LAP:   m_state = M_RUN;
        M_STOP:  m_state = M_IDLE;
        default: m_state = m_state;
      endcase
    end
    m_psw_d = psw;
  endtask

  task automatic check_model(input string name);
    logic [18:0] e;
    logic run, lap;
    run = (m_state == M_RUN || m_state == M_LAP);
    lap = (m_state == M_LAP);
    e = {to_bcd(lap ? m_lap[1] : m_cnt[1]), run, lap, m_ovf[1]};
    chk({name, "_wrap"}, out1, e);
    e = {to_bcd(lap ? m_lap[0] : m_cnt[0]), run, lap, m_ovf[0]};
    chk({name, "_sat"}, out0, e);
  endtask

  task automatic cycle(input logic sec, input logic [3:0] psw);
    @(negedge CLK);
    SEC_SIG = sec;
    PSW_SIG = psw;
    @(posedge CLK);
    model_step(sec, psw);
    #1 check_model("model");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 4'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    SEC_SIG = 1'b0;
    PSW_SIG = 4'd0;
    RSTN = 1'b0;
    #1;
    model_reset();
    check_model("reset_async");
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    model_step(1'b0, 4'd0);
    #1 check_model("reset_release");
  endtask

  initial begin
    RSTN = 1'b0;
    SEC_SIG = 1'b0;
    PSW_SIG = 4'd0;
    model_reset();
    #12;
    do_reset();
    chk("reset_zero_wrap", out1, 19'd0);
    chk("reset_zero_sat", out0, 19'd0);

    // Table: start, ticks with held switch, lap freeze, resume, dual press,
    // clear, and a tick coincident with start from IDLE.
    vecs[0]  = '{1'b0, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd0, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd0, 16'h0003, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd2, 16'h0003, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd2, 16'h0003, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd0, 16'h0003, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd2, 16'h0005, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd3, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd0, 16'h0006, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd2, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 4'd0, 16'h0001, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].sec, vecs[i].psw);
      chk($sformatf("table%0d", i), out1, {vecs[i].seg, vecs[i].run, vecs[i].lap, vecs[i].ovf});
    end

    // Reset while running clears everything without a clock edge.
    do_reset();
    chk("midrun_reset", out1, 19'd0);

    // Held start switch: single event, ten ticks, then stop at 00:10.
    for (int i = 0; i < 50; i++) cycle((i >= 1 && i <= 10) ? 1'b1 : 1'b0, 4'd1);
    chk("hold_run", out1, {16'h0010, 1'b1, 1'b0, 1'b0});
    cycle(1'b0, 4'd0);
    cycle(1'b0, 4'd1);
    ticks(5);
    chk("hold_stop", out1, {16'h0010, 1'b0, 1'b0, 1'b0});

    // Lap freeze and release, then stop and clear.
    do_reset();
    cycle(1'b0, 4'd1);
    ticks(7);
    cycle(1'b0, 4'd2);
    chk("lap_enter", out1, {16'h0007, 1'b1, 1'b1, 1'b0});
    ticks(4);
    chk("lap_frozen", out1, {16'h0007, 1'b1, 1'b1, 1'b0});
    cycle(1'b0, 4'd2);
    chk("lap_release", out1, {16'h0011, 1'b1, 1'b0, 1'b0});
    cycle(1'b0, 4'd1);
    cycle(1'b0, 4'd2);
    chk("lap_clear", out1, {16'h0000, 1'b0, 1'b0, 1'b0});

    // Minutes carry 09:59 -> 10:00.
    do_reset();
    cycle(1'b0, 4'd1);
    ticks(599);
    chk("carry_pre", out1, {16'h0959, 1'b1, 1'b0, 1'b0});
    ticks(1);
    chk("carry_post", out1, {16'h1000, 1'b1, 1'b0, 1'b0});

    // Terminal case: wrap versus saturate, sticky OVF, cleared by STOP->IDLE.
    do_reset();
    cycle(1'b0, 4'd1);
    ticks(3598);
    chk("term_5958", out1, {16'h5958, 1'b1, 1'b0, 1'b0});
    ticks(1);
    chk("term_5959", out1, {16'h5959, 1'b1, 1'b0, 1'b0});
    ticks(1);
    chk("term_wrap", out1, {16'h0000, 1'b1, 1'b0, 1'b1});
    chk("term_sat", out0, {16'h5959, 1'b1, 1'b0, 1'b1});
    ticks(2);
    chk("term_wrap_sticky", out1, {16'h0002, 1'b1, 1'b0, 1'b1});
    chk("term_sat_hold", out0, {16'h5959, 1'b1, 1'b0, 1'b1});
    cycle(1'b0, 4'd1);
    cycle(1'b0, 4'd2);
    chk("ovf_clear_wrap", out1, 19'd0);
    chk("ovf_clear_sat", out0, 19'd0);

    // Randomized stimulus against the model, with sparse resets.
    begin
      logic [3:0] psw;
      psw = 4'd0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 999) == 0) begin
          do_reset();
          psw = 4'd0;
        end else begin
          if ($urandom_range(0, 3) == 0) psw = 4'($urandom_range(0, 15));
          cycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, psw);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
